mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Multi-cycle integer multiply/divide unit with HI/LO registers; it is the next datapath block after the single-cycle core.
//   Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO command per start pulse and models a configurable
//   multi-cycle latency with a busy flag.
//   Sits beside the ALU in the execute stage. Control stalls dependent instructions while busy=1.
// PARAMETERS
//   WIDTH       32  operand and HI/LO width
//   MUL_CYCLES  5   cycles busy stays high for MULT/MULTU (>=1)
//   DIV_CYCLES  10  cycles busy stays high for DIV/DIVU (>=1)
// PORTS
//   clk     in   1      single clock, rising edge
//   reset   in   1      synchronous, active-high
//   start   in   1      command valid; accepted only when busy=0
//   md_op   in   3      command: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
//   src_a   in   WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
//   src_b   in   WIDTH  rt operand (divisor / multiplier)
//   busy    out  1      mul/div in flight
//   done    out  1      one-cycle pulse, coincident with the HI/LO update of a mul/div
//   hi      out  WIDTH  HI register
//   lo      out  WIDTH  LO register
// BEHAVIOUR
//   - Clocking: one clock (clk); reset is synchronous and active-high.
//   - Reset values: hi=0, lo=0, busy=0, done=0, cnt=0, pending result cleared.
//   - Reset during an operation aborts it. No done pulse and no HI/LO write occur afterwards.
//   - States: IDLE (busy=0) and RUN (busy=1).
//   - Accept rule: start=1 & busy=0 & op in 0..5 at edge N.
//     - start while busy=1 is ignored with no side effects. Control must hold the stall.
//     - Reserved ops 6/7 are ignored.
//   - MTHI/MTLO: hi (or lo) <= src_a at edge N. No busy, no done.
//   - MULT/MULTU/DIV/DIVU:
//     - At edge N, compute the full result and latch it into pending_hi/pending_lo.
//     - At edge N, load cnt with LAT-1, where LAT = MUL_CYCLES or DIV_CYCLES.
//     - busy=1 from after edge N through edge N+LAT-1.
//     - At edge N+LAT, hi/lo take the pending values, busy falls, and done=1 for that one cycle.
//     - Back-to-back: a new start is accepted in the cycle when done=1.
//   - Arithmetic:
//     - MULT: {hi,lo} = signed(a)*signed(b), 2*WIDTH bits.
//     - MULTU: the same product, unsigned.
//     - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//     - DIVU: unsigned quotient and remainder.
//   - Boundary cases:
//     - Divide by zero: full latency, done pulses, hi/lo are left unchanged.
//     - DIV of MIN_INT by -1: lo=MIN_INT, hi=0, with no trap.
//     - Operands are sampled only at accept. Later changes to src_a/src_b are ignored.
//   - hi/lo are registered outputs. A read in the same cycle as an update sees the old value.
// STRUCTURE
//   - Shared package mdu_pkg:
//     - md_op_t enum, values 0..5 as listed under PORTS.
//     - localparams MD_OP_W=3 and the default latencies.
//   - One file, no sub-modules. The latency counter is $clog2(max(MUL_CYCLES,DIV_CYCLES)+1) bits.
// TESTING
//   1 Reset: hold reset 2 cycles -> hi=lo=0, busy=0, done=0.
//   2 MULT a=0xFFFFFFFD (-3), b=7 -> busy high 5 cycles,
//     then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse 1 cycle.
//   3 DIVU a=100, b=7 -> busy high 10 cycles, then lo=14, hi=2.
//     DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   4 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//     DIVU b=0 after MTHI 0x55 and MTLO 0xAA -> done pulses, hi=0x55, lo=0xAA unchanged.
//   5 MTHI 0x1234 with start while busy -> ignored, hi unchanged.
//     MULTU 0xFFFFFFFF*2 issued in the done cycle -> accepted; 5 cycles later hi=1, lo=0xFFFFFFFE.
//   6 Assert reset 3 cycles into a DIV -> busy=0, hi=lo=0 next cycle, no done pulse ever follows.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and defaults for the multiply/divide unit.
package mdu_pkg;

    localparam int MD_OP_W        = 3;
    localparam int DEF_MUL_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Latency: MTHI/MTLO write at accept; mul/div results land MUL_CYCLES/DIV_CYCLES edges after accept.
// Backpressure: none; starts seen while busy=1 are dropped, so control must stall on busy.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag, div_s, div_u;
    logic [WIDTH-1:0]   quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;

    // Signed divide works on magnitudes so MIN_INT / -1 wraps to MIN_INT with a zero remainder.
    always_comb begin
        prod_s  = $signed({{WIDTH{src_a[WIDTH-1]}}, src_a}) *
                  $signed({{WIDTH{src_b[WIDTH-1]}}, src_b});
        prod_u  = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
        a_neg   = src_a[WIDTH-1];
        b_neg   = src_b[WIDTH-1];
        b_zero  = (src_b == '0);
        a_mag   = a_neg ? -src_a : src_a;
        b_mag   = b_neg ? -src_b : src_b;
        div_s   = b_zero ? WIDTH'(1) : b_mag;
        div_u   = b_zero ? WIDTH'(1) : src_b;
        quo_mag = a_mag / div_s;
        rem_mag = a_mag % div_s;
        quo_s   = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
        rem_s   = a_neg ? -rem_mag : rem_mag;
        quo_u   = src_a / div_u;
        rem_u   = src_a % div_u;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MTHI: hi_d = src_a;
                        MD_MTLO: lo_d = src_a;
                        MD_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            cnt_d   = MUL_CNT;
                            state_d = S_RUN;
                        end
                        MD_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            cnt_d   = MUL_CNT;
                            state_d = S_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            // Divide by zero retires the current HI/LO, which cannot change while busy.
                            if (b_zero) begin
                                pend_hi_d = hi_q;
                                pend_lo_d = lo_q;
                            end else if (md_op == MD_DIV) begin
                                pend_hi_d = rem_s;
                                pend_lo_d = quo_s;
                            end else begin
                                pend_hi_d = rem_u;
                                pend_lo_d = quo_u;
                            end
                            cnt_d   = DIV_CNT;
                            state_d = S_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a, src_b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mul_div_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Reference: applies one accepted command to m_hi/m_lo and returns the expected busy length.
    function automatic int model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sp, q, r;
        logic [63:0] up;
        logic [63:0] sbits;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin sp = sa * sb; sbits = sp; m_hi = sbits[63:32]; m_lo = sbits[31:0]; return 5; end
            3'd1: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; return 5; end
            3'd2: begin
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    sbits = q; m_lo = sbits[31:0];
                    sbits = r; m_hi = sbits[31:0];
                end
                return 10;
            end
            3'd3: begin
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
                return 10;
            end
            3'd4: begin m_hi = a; return 0; end
            3'd5: begin m_lo = a; return 0; end
            default: return 0;
        endcase
    endfunction

    // Issues one command from idle and observes busy length, done pulses and final HI/LO.
    task automatic exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_n, output int done_n,
                        output logic [31:0] h, output logic [31:0] l);
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'($urandom); src_a = $urandom; src_b = $urandom;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) done_n++;
            if (!busy && (done || op > 3'd3)) break;
        end
        h = hi; l = lo;
        @(negedge clk);
        if (done) done_n++;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; md_op = '0; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++; if (hi !== 32'd0)  begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'd0)  begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        m_hi = '0; m_lo = '0;
    endtask

    task automatic check_op(input string name, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        int busy_n, done_n, lat;
        logic [31:0] h, l;
        exec(op, a, b, busy_n, done_n, h, l);
        lat = model(op, a, b);
        vectors++; if (busy_n !== lat) begin miscompares++; $display("FAIL %s_busy cycles %0d want %0d", name, busy_n, lat); end
        vectors++; if (done_n !== ((lat > 0) ? 1 : 0)) begin miscompares++; $display("FAIL %s_done pulses %0d want %0d", name, done_n, (lat > 0) ? 1 : 0); end
        vectors++; if (h !== m_hi) begin miscompares++; $display("FAIL %s_hi got %h want %h", name, h, m_hi); end
        vectors++; if (l !== m_lo) begin miscompares++; $display("FAIL %s_lo got %h want %h", name, l, m_lo); end
    endtask

    task automatic test_mult;
        check_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
        vectors++; if (m_hi !== 32'hFFFF_FFFF || m_lo !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL model_mult got %h_%h want ffffffff_ffffffeb", m_hi, m_lo); end
    endtask

    task automatic test_div;
        check_op("divu", 3'd3, 32'd100, 32'd7);
        vectors++; if (hi !== 32'd2 || lo !== 32'd14) begin miscompares++; $display("FAIL divu_abs got %h_%h want 2_14", hi, lo); end
        check_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
        vectors++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_neg_abs got %h_%h want ffffffff_fffffffd", hi, lo); end
    endtask

    task automatic test_boundary;
        check_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        vectors++; if (hi !== 32'd0 || lo !== 32'h8000_0000) begin miscompares++; $display("FAIL div_ovf_abs got %h_%h want 0_80000000", hi, lo); end
        check_op("mthi", 3'd4, 32'h55, 32'd0);
        check_op("mtlo", 3'd5, 32'hAA, 32'd0);
        check_op("divu_zero", 3'd3, 32'h1234_5678, 32'd0);
        vectors++; if (hi !== 32'h55 || lo !== 32'hAA) begin miscompares++; $display("FAIL divzero_abs got %h_%h want 55_aa", hi, lo); end
    endtask

    task automatic test_back_to_back;
        int busy_n, lat;
        bit seen;
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk); #1 start = 1'b0;
        lat = model(3'd0, 32'd3, 32'd4);
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got %b want 1", busy); end
        start = 1'b1; md_op = 3'd4; src_a = 32'h1234;
        @(posedge clk); #1 start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL b2b_first_done got 0 want 1 within %0d", lat + 15); end
        vectors++; if (hi !== m_hi || lo !== m_lo) begin miscompares++; $display("FAIL b2b_ignored_mthi got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
        start = 1'b1; md_op = 3'd1; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; src_a = $urandom; src_b = $urandom;
        lat = model(3'd1, 32'hFFFF_FFFF, 32'd2);
        busy_n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) seen = 1;
        end
        vectors++; if (busy_n !== lat) begin miscompares++; $display("FAIL b2b_busy_cycles got %0d want %0d", busy_n, lat); end
        vectors++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL b2b_multu got %h_%h want 1_fffffffe", hi, lo); end
        vectors++; if (hi !== m_hi || lo !== m_lo) begin miscompares++; $display("FAIL b2b_model got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_reset_abort;
        int done_n;
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd0) begin miscompares++; $display("FAIL abort_hilo got %h_%h want 0_0", hi, lo); end
        done_n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        vectors++; if (done_n !== 0) begin miscompares++; $display("FAIL abort_done pulses %0d want 0", done_n); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd0) begin miscompares++; $display("FAIL abort_late_hilo got %h_%h want 0_0", hi, lo); end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int n = 0; n < 30; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            check_op($sformatf("rand%0d_op%0d", n, op), op, a, b);
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_boundary;
        test_back_to_back;
        test_reset_abort;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
